// File: rtl/bmc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bmc_pkg
// Description : Shared definitions for the BMC line encoder: default payload
//               width, encoder state type and the parity helper used when the
//               optional parity cell (BMC_PARITY_EN) is built in.
// Revision    : 1.0 - initial release
// ============================================================================
package bmc_pkg;

    localparam int BLOCK_W_DEFAULT = 28;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Even parity over a zero-extended payload (zero padding does not change
    // the XOR reduction). Supports payloads up to 64 bits.
    function automatic logic even_parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bmc_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : bmc_encoder_if
// Description : Block-in / line-out bundle of the BMC encoder.
//               master : block source (drives valid_in, i_block)
//               slave  : encoder (drives ready_out, o_bmc, valid_out, busy,
//                        done)
// Revision    : 1.0 - initial release
// ============================================================================
interface bmc_encoder_if
    import bmc_pkg::*;
#(
    parameter int BLOCK_W = BLOCK_W_DEFAULT
) ();

    logic               valid_in;
    logic [BLOCK_W-1:0] i_block;
    logic               ready_out;
    logic               o_bmc;
    logic               valid_out;
    logic               busy;
    logic               done;

    modport master (
        output valid_in, i_block,
        input  ready_out, o_bmc, valid_out, busy, done
    );

    modport slave (
        input  valid_in, i_block,
        output ready_out, o_bmc, valid_out, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/bmc_cell_strobe.sv
`default_nettype none
// ============================================================================
// Module      : bmc_cell_strobe
// Description : Half-bit cell timer. Restarted by i_start (the accept cycle),
//               it raises o_tick once every HALF_PERIOD cycles while i_run is
//               high, the first tick landing HALF_PERIOD cycles after start.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               i_start    - restart the divider
//               i_run      - divider counts while high
//               o_tick     - half-cell boundary strobe
// Revision    : 1.0 - initial release
// ============================================================================
module bmc_cell_strobe #(
    parameter int HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_run,
    output logic o_tick
);

    localparam int                 c_cnt_w   = $clog2(HALF_PERIOD) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(HALF_PERIOD);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;

    // Counts 1..HALF_PERIOD; loading 1 on start puts the first tick exactly
    // HALF_PERIOD cycles after the accept. With HALF_PERIOD=1 the count
    // sits at 1 and every running cycle ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= c_cnt_one;
        end else if (i_run) begin
            r_cnt <= (r_cnt == c_cnt_max) ? c_cnt_one : r_cnt + c_cnt_one;
        end
    end

    assign o_tick = i_run && (r_cnt == c_cnt_max);

endmodule
`default_nettype wire

// File: rtl/bmc_encoder.sv
`default_nettype none
// ============================================================================
// Module      : bmc_encoder
// Description : Serialises one BLOCK_W-bit word, MSB first, into a Biphase
//               Mark Coded line. Each bit cell is two half-cells: the line
//               toggles at the start of every cell and toggles again mid-cell
//               for a 1. valid_out strobes once per half-cell update.
//               Build option: define BMC_PARITY_EN to append one even-parity
//               cell after the payload.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               bus (slave)     - valid_in/i_block in; ready_out, o_bmc,
//                                 valid_out, busy, done out
// Revision    : 1.0 - initial release
// ============================================================================
module bmc_encoder
    import bmc_pkg::*;
#(
    parameter int   BLOCK_W     = BLOCK_W_DEFAULT,
    parameter int   HALF_PERIOD = 4,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    bmc_encoder_if.slave bus
);

`ifdef BMC_PARITY_EN
    localparam int c_ncells = BLOCK_W + 1;
`else
    localparam int c_ncells = BLOCK_W;
`endif
    localparam int c_nhalf  = 2 * c_ncells;
    localparam int c_hidx_w = $clog2(c_nhalf) + 1;

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_ready;
    logic                 w_busy;
    logic                 w_accept;
    logic                 w_emit;
    logic                 w_finish;
    logic                 w_tick;
    logic                 w_last;
    logic                 w_phase;
    logic [c_ncells-1:0]  w_load;
    logic [c_ncells-1:0]  r_shreg;
    logic [c_hidx_w-1:0]  r_half_idx;
    logic                 r_bmc;
    logic                 r_valid;
    logic                 r_done;

`ifdef BMC_PARITY_EN
    assign w_load = {bus.i_block, even_parity(64'(bus.i_block))};
`else
    assign w_load = bus.i_block;
`endif

    bmc_cell_strobe #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_strobe (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_accept),
        .i_run   (w_busy),
        .o_tick  (w_tick)
    );

    // r_half_idx counts half-cells already on the line; once it reaches
    // c_nhalf the next tick closes the final cell instead of emitting.
    assign w_last  = (r_half_idx == c_hidx_w'(c_nhalf));
    // Odd index: the next half-cell is the second half of the current bit.
    assign w_phase = r_half_idx[0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.valid_in)     w_next_state = SEND;
            SEND:    if (w_tick && w_last) w_next_state = IDLE;
            default:                       w_next_state = IDLE;
        endcase
    end

    // State-derived controls
    always_comb begin
        w_ready  = (r_state == IDLE);
        w_busy   = (r_state == SEND);
        w_accept = w_ready && bus.valid_in;
        w_emit   = w_busy && w_tick && !w_last;
        w_finish = w_busy && w_tick && w_last;
    end

    // Datapath. The accept edge already emits the first half-cell, so the
    // line level is never reloaded between blocks: it carries over.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bmc      <= IDLE_LEVEL;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_shreg    <= '0;
            r_half_idx <= '0;
        end else begin
            r_valid <= w_accept || w_emit;
            r_done  <= w_finish;
            if (w_accept) begin
                r_bmc      <= ~r_bmc;
                r_shreg    <= w_load;
                r_half_idx <= c_hidx_w'(1);
            end else if (w_emit) begin
                r_half_idx <= r_half_idx + c_hidx_w'(1);
                if (!w_phase) begin
                    r_bmc <= ~r_bmc;
                end else begin
                    if (r_shreg[c_ncells-1]) begin
                        r_bmc <= ~r_bmc;
                    end
                    r_shreg <= r_shreg << 1;
                end
            end
        end
    end

    assign bus.ready_out = w_ready;
    assign bus.busy      = w_busy;
    assign bus.o_bmc     = r_bmc;
    assign bus.valid_out = r_valid;
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bmc_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bmc_encoder
// Description : Self-checking bench for bmc_encoder. A cycle-indexed model
//               derives the expected line level and strobes arithmetically
//               from the accepted word; a BMC decoder model recovers words
//               from the strobed levels. Directed and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bmc_encoder;

    localparam int BW = 28;
    localparam int HP = 4;
`ifdef BMC_PARITY_EN
    localparam int NC    = BW + 1;
    localparam int c_LAT = 233;
    localparam int c_NSTB = 58;
`else
    localparam int NC    = BW;
    localparam int c_LAT = 225;
    localparam int c_NSTB = 56;
`endif
    localparam int NH = 2 * NC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bmc_encoder_if #(.BLOCK_W(BW)) bus ();

    bmc_encoder #(
        .BLOCK_W     (BW),
        .HALF_PERIOD (HP),
        .IDLE_LEVEL  (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit             m_on       = 1'b0;
    bit             m_active   = 1'b0;
    int             m_T        = 0;
    int             m_done_cyc = -1;
    logic           m_lvl0     = 1'b0;
    logic           m_idle_lvl = 1'b0;
    logic           m_bits [NC];
    logic [NC-1:0]  m_cw;
    logic [NC-1:0]  exp_words [$];

    function automatic logic [NC-1:0] cells_of(input logic [BW-1:0] w);
`ifdef BMC_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    // Level after half-cells 0..k: one toggle per cell start, one per 1 bit.
    function automatic logic lvl_after(input int k);
        logic l = m_lvl0;
        for (int j = 0; j <= k; j++)
            if ((j % 2) == 0 || m_bits[j / 2]) l = ~l;
        return l;
    endfunction

    function automatic logic exp_level(input int c);
        int d;
        if (!m_active) return m_idle_lvl;
        d = c - m_T;
        if (d <= 0) return m_lvl0;
        if (d > NH * HP) return lvl_after(NH - 1);
        return lvl_after((d - 1) / HP);
    endfunction

    function automatic logic exp_ready(input int c);
        return !m_active || ((c - m_T) > NH * HP);
    endfunction

    function automatic logic exp_valid(input int c);
        int d = c - m_T;
        return m_active && d >= 1 && d <= NH * HP && ((d - 1) % HP) == 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_on       = 1'b1;
            m_active   = 1'b0;
            m_idle_lvl = 1'b0;
            m_done_cyc = -1;
            exp_words.delete();
        end else if (m_on && bus.valid_in && exp_ready(cyc)) begin
            m_lvl0 = exp_level(cyc);
            m_cw   = cells_of(bus.i_block);
            for (int i = 0; i < NC; i++) m_bits[i] = m_cw[NC-1-i];
            m_T        = cyc;
            m_active   = 1'b1;
            m_done_cyc = cyc + NH * HP + 1;
            exp_words.push_back(m_cw);
        end
        cyc++;
    end

    // ---------------- compare + decoder ----------------
    typedef struct { int c; logic l; } strobe_t;
    strobe_t slog [$];
    logic    dec_q [$];
    logic    dec_prev = 1'b0;

    task automatic decode_block();
        logic [NC-1:0] got;
        logic          first_ok;
        logic          prev;
        chk("strobes_per_block", dec_q.size(), NH);
        if (exp_words.size() == 0) begin
            chk("done_without_block", 1, 0);
        end else if (dec_q.size() == NH) begin
            got      = '0;
            first_ok = 1'b1;
            prev     = dec_prev;
            for (int i = 0; i < NC; i++) begin
                if (dec_q[2*i] == prev) first_ok = 1'b0;
                got[NC-1-i] = dec_q[2*i] ^ dec_q[2*i+1];
                prev = dec_q[2*i+1];
            end
            chk("decoded_word", got, exp_words.pop_front());
            chk("cell_start_toggle", first_ok, 1);
            dec_prev = prev;
        end else begin
            void'(exp_words.pop_front());
        end
        dec_q.delete();
    endtask

    always @(negedge clk) begin
        if (m_on) begin
            chk("ready_out", bus.ready_out, exp_ready(cyc));
            chk("busy",      bus.busy,      !exp_ready(cyc));
            chk("valid_out", bus.valid_out, exp_valid(cyc));
            chk("done",      bus.done,      cyc == m_done_cyc);
            chk("o_bmc",     bus.o_bmc,     exp_level(cyc));
            if (bus.valid_out) begin
                dec_q.push_back(bus.o_bmc);
                slog.push_back('{cyc, bus.o_bmc});
            end
            if (bus.done) decode_block();
            if (rst) begin
                dec_q.delete();
                dec_prev = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [BW-1:0] w, output int t);
        int n = 0;
        while (!bus.ready_out && n < 2000) begin step(); n++; end
        if (n >= 2000) chk("ready_timeout", 0, 1);
        bus.valid_in = 1'b1;
        bus.i_block  = w;
        t = cyc;
        step();
        bus.valid_in = 1'b0;
        bus.i_block  = BW'($urandom());
    endtask

    task automatic wait_done(output int dc);
        int n = 0;
        while (!bus.done && n < 2000) begin step(); n++; end
        if (n >= 2000) chk("done_timeout", 0, 1);
        dc = cyc;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, dc, dc2, seen, mode;
        logic [BW-1:0] w, w2;
        logic          spacing_ok;
        bus.valid_in = 1'b0;
        bus.i_block  = '0;
        repeat (3) step();
        rst = 1'b0;

        // reset values
        chk("rst_o_bmc",     bus.o_bmc,     0);
        chk("rst_ready",     bus.ready_out, 1);
        chk("rst_busy",      bus.busy,      0);
        chk("rst_valid_out", bus.valid_out, 0);
        chk("rst_done",      bus.done,      0);

        // all-zero block from level 0
        slog.delete();
        send(28'h0000000, t);
        wait_done(dc);
        chk("zero_done_cycle", dc, t + c_LAT);
        chk("zero_strobes", slog.size(), c_NSTB);
        if (slog.size() >= 6) begin
            chk("zero_first_strobe", slog[0].c, t + 1);
            chk("zero_lvl0", slog[0].l, 1);
            chk("zero_lvl1", slog[1].l, 1);
            chk("zero_lvl2", slog[2].l, 0);
            chk("zero_lvl3", slog[3].l, 0);
            chk("zero_lvl4", slog[4].l, 1);
            chk("zero_lvl5", slog[5].l, 1);
            spacing_ok = 1'b1;
            for (int i = 1; i < slog.size(); i++)
                if (slog[i].c - slog[i-1].c != 4) spacing_ok = 1'b0;
            chk("zero_spacing", spacing_ok, 1);
        end

        // all-ones block
        slog.delete();
        send(28'hFFFFFFF, t);
        wait_done(dc);
        if (slog.size() >= 4) begin
            chk("ones_lvl0", slog[0].l, 1);
            chk("ones_lvl1", slog[1].l, 0);
            chk("ones_lvl2", slog[2].l, 1);
            chk("ones_lvl3", slog[3].l, 0);
        end
`ifndef BMC_PARITY_EN
        chk("ones_final_level", bus.o_bmc, 0);
`endif

        // back-to-back with valid_in held
        while (!bus.ready_out) step();
        bus.valid_in = 1'b1;
        bus.i_block  = 28'hA5A5A5A;
        t = cyc;
        step();
        bus.i_block = 28'h5A5A5A5;
        wait_done(dc);
        chk("b2b_first_done", dc, t + c_LAT);
        step();
        bus.valid_in = 1'b0;
        chk("b2b_second_started", bus.valid_out, 1);
        chk("b2b_second_busy",    bus.busy,      1);
        wait_done(dc2);
        chk("b2b_second_done", dc2, dc + c_LAT);

        // valid pulse while busy is ignored
        send(BW'($urandom()), t);
        wait_until(t + 41);
        bus.valid_in = 1'b1;
        bus.i_block  = 28'h1234567;
        chk("busy_not_ready", bus.ready_out, 0);
        step();
        bus.valid_in = 1'b0;
        wait_done(dc);
        chk("busy_pulse_done", dc, t + c_LAT);

        // reset mid-block
        send(BW'($urandom()), t);
        wait_until(t + 41);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_o_bmc", bus.o_bmc,     0);
        chk("abort_ready", bus.ready_out, 1);
        chk("abort_busy",  bus.busy,      0);
        seen = 0;
        repeat (300) begin
            step();
            if (bus.done) seen = 1;
        end
        chk("abort_no_done", seen, 0);
        send(BW'($urandom()), t);
        wait_done(dc);
        chk("after_abort_done", dc, t + c_LAT);

`ifdef BMC_PARITY_EN
        slog.delete();
        send(28'h0000001, t);
        wait_done(dc);
        chk("par_strobes", slog.size(), 58);
        if (slog.size() == 58) chk("par_last_cell_one", slog[57].l != slog[56].l, 1);
`endif

        // random traffic
        for (int i = 0; i < 10; i++) begin
            w    = BW'($urandom());
            mode = $urandom_range(0, 2);
            send(w, t);
            if (mode == 1) begin
                wait_until(t + 1 + $urandom_range(0, NH * HP - 1));
                bus.valid_in = 1'b1;
                bus.i_block  = BW'($urandom());
                step();
                bus.valid_in = 1'b0;
                wait_done(dc);
            end else if (mode == 2) begin
                w2 = BW'($urandom());
                bus.valid_in = 1'b1;
                bus.i_block  = w2;
                wait_done(dc);
                step();
                bus.valid_in = 1'b0;
                wait_done(dc);
            end else begin
                wait_done(dc);
            end
            repeat ($urandom_range(0, 3)) step();
        end
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
